// File: rtl/ts_pkg.sv
// Shared state encoding and field widths for the time-stamp scheduler.
// TS_HOURS_EN widens the snapshot from {min, sec} to {hours, min, sec}.
package ts_pkg;

    typedef enum logic [1:0] {
        OV_IDLE = 2'd0,
        OV_PEND = 2'd1,
        OV_CLR  = 2'd2,
        OV_WAIT = 2'd3
    } ov_state_t;

    localparam int TS_SEC_W = 6;
    localparam int TS_MIN_W = 6;
    localparam int TS_HR_W  = 5;

`ifdef TS_HOURS_EN
    localparam int TS_DATA_W = TS_HR_W + TS_MIN_W + TS_SEC_W;
`else
    localparam int TS_DATA_W = TS_MIN_W + TS_SEC_W;
`endif

endpackage

// File: rtl/ts_rr_arbiter.sv
// Two-way round-robin snapshot arbiter; registers the timestamp on each grant.
// Latency: request to grant/data is one cycle when not blacked out.
// Backpressure: no grant while i_blackout is high; the holder of the current grant is masked for one cycle.
module ts_rr_arbiter
    import ts_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic [1:0]           i_req,
    input  logic                 i_blackout,
    input  logic [TS_DATA_W-1:0] i_data,
    output logic [1:0]           o_gnt,
    output logic                 o_valid,
    output logic [TS_DATA_W-1:0] o_data
);

    logic                 r_rr;
    logic [1:0]           r_gnt;
    logic                 r_valid;
    logic [TS_DATA_W-1:0] r_data;
    logic [1:0]           w_req_eff;
    logic [1:0]           w_gnt;
    logic                 w_other;

    // A requester still sees its grant this cycle and drops req only afterwards.
    always_comb begin
        w_req_eff = i_req & ~r_gnt;
        w_other   = ~r_rr;
        w_gnt     = 2'b00;
        if (!i_blackout) begin
            if (w_req_eff[r_rr]) begin
                w_gnt[r_rr] = 1'b1;
            end else if (w_req_eff[w_other]) begin
                w_gnt[w_other] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rr    <= 1'b0;
            r_gnt   <= 2'b00;
            r_valid <= 1'b0;
            r_data  <= '0;
        end else begin
            r_gnt   <= w_gnt;
            r_valid <= |w_gnt;
            if (|w_gnt) begin
                r_data <= i_data;
                r_rr   <= w_gnt[0];
            end
        end
    end

    assign o_gnt   = r_gnt;
    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/time_stamp_scheduler.sv
// Second-tick prescaler, counter overflow handshake and coherent snapshot arbiter (TS_HOURS_EN adds hours).
// Latency: ovf_in->ovf_irq and ovf_ack->rst_ovf one cycle; req->gnt one cycle, three around a tick.
// Backpressure: grants are held off in the tick cycle and the one after; a tick colliding with rst_ovf slips one cycle.
module time_stamp_scheduler
    import ts_pkg::*;
#(
    parameter int PRESCALE = 1_000_000,
    parameter int PRE_W    = 24
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 run,
    output logic                 tick_en,
    input  logic [TS_SEC_W-1:0]  sec_in,
    input  logic [TS_MIN_W-1:0]  min_in,
    input  logic                 ovf_in,
    output logic                 rst_ovf,
    output logic                 ovf_irq,
    input  logic                 ovf_ack,
    input  logic [1:0]           req,
    output logic [1:0]           gnt,
    output logic                 ts_valid,
    output logic [TS_DATA_W-1:0] ts_data
);

    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRESCALE - 1);

    ov_state_t            r_ov_state;
    ov_state_t            w_ov_next;
    logic [PRE_W-1:0]     r_pre_cnt;
    logic                 r_tick;
    logic                 r_tick_d;
    logic                 r_tick_defer;
    logic                 r_wait_cnt;
    logic                 r_rst_ovf;
    logic                 r_ovf_irq;
    logic                 w_tick_raw;
    logic                 w_tick_due;
    logic                 w_clr_next;
    logic [TS_DATA_W-1:0] w_snap;

    assign w_tick_raw = (r_pre_cnt == PRE_MAX);
    assign w_tick_due = w_tick_raw | r_tick_defer;
    assign w_clr_next = (w_ov_next == OV_CLR);

    // pre_cnt only reaches PRE_MAX while running, so the wrap tick survives run falling.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pre_cnt    <= '0;
            r_tick       <= 1'b0;
            r_tick_d     <= 1'b0;
            r_tick_defer <= 1'b0;
        end else begin
            if (w_tick_raw || !run) begin
                r_pre_cnt <= '0;
            end else begin
                r_pre_cnt <= r_pre_cnt + PRE_W'(1);
            end
            r_tick       <= w_tick_due & ~w_clr_next;
            r_tick_defer <= w_tick_due & w_clr_next;
            r_tick_d     <= r_tick;
        end
    end

    always_comb begin
        w_ov_next = r_ov_state;
        case (r_ov_state)
            OV_IDLE: if (ovf_in) w_ov_next = OV_PEND;
            OV_PEND: if (ovf_ack) w_ov_next = OV_CLR;
            OV_CLR:  w_ov_next = OV_WAIT;
            OV_WAIT: begin
                if (!ovf_in) begin
                    w_ov_next = OV_IDLE;
                end else if (r_wait_cnt) begin
                    w_ov_next = OV_PEND;
                end
            end
            default: w_ov_next = OV_IDLE;
        endcase
    end

    // Two WAIT cycles give the counter time to drop its flag before retrying.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ov_state <= OV_IDLE;
            r_wait_cnt <= 1'b0;
            r_rst_ovf  <= 1'b0;
            r_ovf_irq  <= 1'b0;
        end else begin
            r_ov_state <= w_ov_next;
            r_wait_cnt <= (r_ov_state == OV_WAIT) && (w_ov_next == OV_WAIT);
            r_rst_ovf  <= w_clr_next;
            r_ovf_irq  <= (w_ov_next == OV_PEND);
        end
    end

`ifdef TS_HOURS_EN
    logic [TS_HR_W-1:0] r_hours;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hours <= '0;
        end else if (w_clr_next) begin
            r_hours <= (r_hours == TS_HR_W'(23)) ? '0 : r_hours + TS_HR_W'(1);
        end
    end

    assign w_snap = {r_hours, min_in, sec_in};
`else
    assign w_snap = {min_in, sec_in};
`endif

    ts_rr_arbiter u_arb (
        .clk        (clk),
        .reset      (reset),
        .i_req      (req),
        .i_blackout (r_tick | r_tick_d),
        .i_data     (w_snap),
        .o_gnt      (gnt),
        .o_valid    (ts_valid),
        .o_data     (ts_data)
    );

    assign tick_en = r_tick;
    assign rst_ovf = r_rst_ovf;
    assign ovf_irq = r_ovf_irq;

endmodule

// File: tb/tb_time_stamp_scheduler.sv
// Self-checking bench for time_stamp_scheduler with PRESCALE=4; grant snapshots go through a scoreboard queue.
module tb_time_stamp_scheduler;
    import ts_pkg::*;

    localparam int W = TS_DATA_W;

    logic                clk     = 1'b0;
    logic                reset   = 1'b0;
    logic                run     = 1'b0;
    logic                ovf_in  = 1'b0;
    logic                ovf_ack = 1'b0;
    logic [TS_SEC_W-1:0] sec_in  = '0;
    logic [TS_MIN_W-1:0] min_in  = '0;
    logic [1:0]          req     = 2'b00;
    logic                tick_en, rst_ovf, ovf_irq, ts_valid;
    logic [1:0]          gnt;
    logic [W-1:0]        ts_data;

    int n_vec = 0;
    int n_err = 0;
`ifdef TS_HOURS_EN
    logic [TS_HR_W-1:0] hours_exp = '0;
`endif

    typedef struct packed {
        logic [1:0]   g;
        logic [W-1:0] d;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    time_stamp_scheduler #(.PRESCALE(4), .PRE_W(3)) dut (
        .clk      (clk),
        .reset    (reset),
        .run      (run),
        .tick_en  (tick_en),
        .sec_in   (sec_in),
        .min_in   (min_in),
        .ovf_in   (ovf_in),
        .rst_ovf  (rst_ovf),
        .ovf_irq  (ovf_irq),
        .ovf_ack  (ovf_ack),
        .req      (req),
        .gnt      (gnt),
        .ts_valid (ts_valid),
        .ts_data  (ts_data)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] snap(input logic [TS_MIN_W-1:0] m, input logic [TS_SEC_W-1:0] s);
`ifdef TS_HOURS_EN
        return {hours_exp, m, s};
`else
        return {m, s};
`endif
    endfunction

    task automatic push_exp(input logic [1:0] g, input logic [W-1:0] d);
        exp_t e;
        e.g = g;
        e.d = d;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        run   = 1'b0;
        repeat (2) step();
        n_vec++;
        if ({tick_en, rst_ovf, ovf_irq, gnt, ts_valid} !== 6'b0) begin
            n_err++;
            $display("FAIL reset_ctrl: got %b want 000000", {tick_en, rst_ovf, ovf_irq, gnt, ts_valid});
        end
        n_vec++;
        if (ts_data !== '0) begin
            n_err++;
            $display("FAIL reset_data: got %h want 0", ts_data);
        end
        run   = 1'b1;
        reset = 1'b1;
    endtask

    task automatic test_prescaler();
        logic exp_tick;
        for (int k = 1; k <= 19; k++) begin
            step();
            exp_tick = (k == 4) || (k == 8) || (k == 18);
            n_vec++;
            if (tick_en !== exp_tick) begin
                n_err++;
                $display("FAIL tick cycle %0d: got %b want %b", k, tick_en, exp_tick);
            end
            if (k == 8)  run = 1'b0;
            if (k == 14) run = 1'b1;
        end
        run = 1'b0;
        repeat (3) step();
    endtask

    task automatic test_overflow();
        logic exp_irq, exp_rst;
        ovf_in = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            step();
            exp_irq = (k <= 5);
            exp_rst = (k == 6);
            n_vec++;
            if ({ovf_irq, rst_ovf} !== {exp_irq, exp_rst}) begin
                n_err++;
                $display("FAIL ovf +%0d: got irq,rst=%b%b want %b%b", k, ovf_irq, rst_ovf, exp_irq, exp_rst);
            end
            if (k == 5) begin
                ovf_ack = 1'b1;
`ifdef TS_HOURS_EN
                hours_exp++;
`endif
            end
            if (k == 6) ovf_ack = 1'b0;
            if (k == 7) ovf_in = 1'b0;
        end
        ovf_ack = 1'b1;
        step();
        ovf_ack = 1'b0;
        n_vec++;
        if ({ovf_irq, rst_ovf} !== 2'b00) begin
            n_err++;
            $display("FAIL ack_idle: got irq,rst=%b%b want 00", ovf_irq, rst_ovf);
        end
    endtask

    task automatic test_ovf_retry();
        ovf_in = 1'b1;
        step();
        ovf_ack = 1'b1;
`ifdef TS_HOURS_EN
        hours_exp++;
`endif
        step();
        ovf_ack = 1'b0;
        n_vec++;
        if (rst_ovf !== 1'b1) begin
            n_err++;
            $display("FAIL retry_clr: got rst=%b want 1", rst_ovf);
        end
        for (int k = 1; k <= 3; k++) begin
            step();
            n_vec++;
            if ({ovf_irq, rst_ovf} !== {(k == 3), 1'b0}) begin
                n_err++;
                $display("FAIL retry +%0d: got irq,rst=%b%b want %b0", k, ovf_irq, rst_ovf, (k == 3));
            end
        end
        ovf_ack = 1'b1;
`ifdef TS_HOURS_EN
        hours_exp++;
`endif
        step();
        ovf_ack = 1'b0;
        ovf_in  = 1'b0;
        repeat (2) step();
        n_vec++;
        if ({ovf_irq, rst_ovf} !== 2'b00) begin
            n_err++;
            $display("FAIL retry_idle: got irq,rst=%b%b want 00", ovf_irq, rst_ovf);
        end
    endtask

    task automatic test_round_robin();
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            req    = 2'b11;
            sec_in = TS_SEC_W'(10 + 3 * i);
            min_in = TS_MIN_W'(20 + i);
            push_exp((i % 2 == 0) ? 2'b01 : 2'b10, snap(min_in, sec_in));
            step();
            n_vec++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL rr %0d: scoreboard empty, got gnt=%b", i, gnt);
            end else begin
                e = sb.pop_front();
                if ({ts_valid, gnt, ts_data} !== {1'b1, e.g, e.d}) begin
                    n_err++;
                    $display("FAIL rr %0d: got v=%b gnt=%b data=%h want v=1 gnt=%b data=%h",
                             i, ts_valid, gnt, ts_data, e.g, e.d);
                end
            end
        end
        req = 2'b00;
        step();
        n_vec++;
        if ({ts_valid, gnt} !== 3'b000) begin
            n_err++;
            $display("FAIL rr_idle: got v=%b gnt=%b want 0 00", ts_valid, gnt);
        end
    endtask

    task automatic test_tick_blackout();
        exp_t e;
        logic found = 1'b0;
        run = 1'b1;
        for (int k = 0; k < 12 && !found; k++) begin
            step();
            if (tick_en) found = 1'b1;
        end
        n_vec++;
        if (!found) begin
            n_err++;
            $display("FAIL tick_wait: got no tick in 12 cycles want tick");
        end else begin
            req    = 2'b01;
            sec_in = 6'd59;
            min_in = 6'd5;
            step();
            sec_in = 6'd0;
            min_in = 6'd6;
            push_exp(2'b01, snap(6'd6, 6'd0));
            n_vec++;
            if (gnt !== 2'b00) begin
                n_err++;
                $display("FAIL blackout_t1: got gnt=%b want 00", gnt);
            end
            step();
            n_vec++;
            if (gnt !== 2'b00) begin
                n_err++;
                $display("FAIL blackout_t2: got gnt=%b want 00", gnt);
            end
            step();
            req = 2'b00;
            n_vec++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL blackout_gnt: scoreboard empty, got gnt=%b", gnt);
            end else begin
                e = sb.pop_front();
                if ({ts_valid, gnt, ts_data} !== {1'b1, e.g, e.d}) begin
                    n_err++;
                    $display("FAIL blackout_gnt: got v=%b gnt=%b data=%h want v=1 gnt=%b data=%h",
                             ts_valid, gnt, ts_data, e.g, e.d);
                end
            end
        end
        run = 1'b0;
        repeat (4) step();
    endtask

    task automatic test_tick_vs_clear();
        logic found = 1'b0;
        run = 1'b1;
        for (int k = 0; k < 12 && !found; k++) begin
            step();
            if (tick_en) found = 1'b1;
        end
        n_vec++;
        if (!found) begin
            n_err++;
            $display("FAIL tick_wait2: got no tick in 12 cycles want tick");
        end else begin
            step();
            ovf_in = 1'b1;
            step();
            step();
            ovf_ack = 1'b1;
`ifdef TS_HOURS_EN
            hours_exp++;
`endif
            step();
            ovf_ack = 1'b0;
            ovf_in  = 1'b0;
            n_vec++;
            if ({rst_ovf, tick_en} !== 2'b10) begin
                n_err++;
                $display("FAIL tick_suppress: got rst,tick=%b%b want 10", rst_ovf, tick_en);
            end
            step();
            n_vec++;
            if ({rst_ovf, tick_en} !== 2'b01) begin
                n_err++;
                $display("FAIL tick_deferred: got rst,tick=%b%b want 01", rst_ovf, tick_en);
            end
            step();
            n_vec++;
            if (tick_en !== 1'b0) begin
                n_err++;
                $display("FAIL tick_after_defer: got %b want 0", tick_en);
            end
        end
        run = 1'b0;
        repeat (4) step();
    endtask

    task automatic test_reset_mid();
        exp_t e;
        ovf_in = 1'b1;
        req    = 2'b01;
        sec_in = 6'd3;
        min_in = 6'd4;
        push_exp(2'b01, snap(6'd4, 6'd3));
        step();
        n_vec++;
        e = sb.pop_front();
        if ({ovf_irq, ts_valid, gnt, ts_data} !== {1'b1, 1'b1, e.g, e.d}) begin
            n_err++;
            $display("FAIL pre_reset: got irq=%b v=%b gnt=%b data=%h want 1 1 %b %h",
                     ovf_irq, ts_valid, gnt, ts_data, e.g, e.d);
        end
        #2 reset = 1'b0;
        #1;
        n_vec++;
        if ({tick_en, rst_ovf, ovf_irq, gnt, ts_valid, ts_data} !== {6'b0, {W{1'b0}}}) begin
            n_err++;
            $display("FAIL mid_reset: got ctrl=%b data=%h want 000000 0",
                     {tick_en, rst_ovf, ovf_irq, gnt, ts_valid}, ts_data);
        end
        ovf_in = 1'b0;
        req    = 2'b11;
`ifdef TS_HOURS_EN
        hours_exp = '0;
`endif
        @(negedge clk);
        reset = 1'b1;
        push_exp(2'b01, snap(6'd4, 6'd3));
        step();
        req = 2'b00;
        n_vec++;
        e = sb.pop_front();
        if ({ts_valid, gnt, ts_data} !== {1'b1, e.g, e.d}) begin
            n_err++;
            $display("FAIL post_reset_rr: got v=%b gnt=%b data=%h want v=1 gnt=%b data=%h",
                     ts_valid, gnt, ts_data, e.g, e.d);
        end
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_prescaler();
        test_overflow();
        test_ovf_retry();
        test_round_robin();
        test_tick_blackout();
        test_tick_vs_clear();
        test_reset_mid();
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d entries want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/time_stamp_scheduler.md
# time_stamp_scheduler

Controller that sequences the seconds/minutes time counter and shares its value between two requesters. It generates the one-cycle second tick from the system clock and runs the overflow-acknowledge handshake that drives the counter's `rst_ovf`. It also arbitrates round-robin snapshot reads of `{min, sec}` so each reader gets a coherent timestamp. It sits between the time counter and the spectrogram framing/readout logic.

## Interface
- `PRESCALE`, 1_000_000: clk cycles per second tick; legal range 2..2^24.
- `PRE_W`, 24: prescaler counter width; must satisfy 2^PRE_W ≥ PRESCALE.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset (0 = reset asserted).
- `run`  in  1  1 = timebase advances; 0 = prescaler held at 0, no ticks.
- `tick_en`  out  1  one-cycle pulse every PRESCALE cycles while `run`=1; drives the counter's clock enable.
- `sec_in`  in  6  counter seconds.
- `min_in`  in  6  counter minutes.
- `ovf_in`  in  1  counter overflow flag.
- `rst_ovf`  out  1  one-cycle clear pulse to the counter.
- `ovf_irq`  out  1  level; overflow pending acknowledge.
- `ovf_ack`  in  1  host acknowledge, sampled only while `ovf_irq`=1.
- `req`  in  2  snapshot requests; level, held until granted.
- `gnt`  out  2  one-hot grant pulse, one cycle.
- `ts_valid`  out  1  high in the same cycle as `gnt`.
- `ts_data`  out  12 (17 with TS_HOURS_EN)  snapshot `{min_in, sec_in}`, or `{hours, min_in, sec_in}` with TS_HOURS_EN.

## Operation
- **Prescaler**
  - `pre_cnt` counts 0..PRESCALE-1 while `run`=1.
  - `tick_en`=1 in the cycle where `pre_cnt`==PRESCALE-1; the count then wraps to 0.
  - `run`=0 clears `pre_cnt` synchronously. First tick after `run` rises comes PRESCALE cycles later.
- **Overflow FSM** (states OV_IDLE, OV_PEND, OV_CLR, OV_WAIT)
  - OV_IDLE: `ovf_in`=1 → OV_PEND.
  - OV_PEND: `ovf_irq`=1; `ovf_ack`=1 → OV_CLR.
  - OV_CLR: `rst_ovf`=1 for exactly this one cycle → OV_WAIT.
  - OV_WAIT: `ovf_in`=0 → OV_IDLE. If `ovf_in` is still 1 after 2 cycles, return to OV_PEND (clear failed).
  - `tick_en` is suppressed during OV_CLR, because the counter ignores increments while `rst_ovf`=1. The suppressed tick is not lost: it is issued in the following cycle.
  - `ovf_ack` outside OV_PEND is ignored.
- **Arbiter**
  - Round-robin pointer `rr`, reset value 0 (req[0] has priority first).
  - Grant is allowed only in a cycle where `tick_en`=0, and also not the cycle after a tick, so inputs are settled.
  - On grant: `gnt[i]`=1, `ts_valid`=1, `ts_data` registered from the inputs. `rr` then points to the other requester.
  - Both requesters active: alternating grants, one per eligible cycle.
  - Requester `i` must drop `req[i]` the cycle after `gnt[i]`. If held, it is re-granted subject to round-robin.

## Timing
- Reset values: `tick_en`, `rst_ovf`, `ovf_irq`, `gnt`, `ts_valid` = 0; `ts_data` = 0; FSM = OV_IDLE; `pre_cnt` = 0; `rr` = 0.
- All outputs are registered.
- Latencies:
  - `ovf_in` rise → `ovf_irq` = 1 cycle.
  - `ovf_ack` → `rst_ovf` = 1 cycle.
  - `req` → `gnt` = 1 cycle when eligible; at most 3 cycles with one contender plus a tick blackout.
- Simultaneous events:
  - `ovf_in` with `req`: both proceed independently.
  - Tick with grant eligibility: the grant is deferred.
  - `run` falling on a tick cycle: the tick is still issued.
- Reset mid-operation: all state is cleared asynchronously. Outputs go to reset values immediately, with no pending grant or pulse.

## Configuration
- `TS_HOURS_EN` defined:
  - Adds a 5-bit `hours` counter, incremented on each OV_CLR entry and wrapping 23→0.
  - `ts_data` becomes 17 bits `{hours, min, sec}`.
- `TS_HOURS_EN` undefined: no hours logic; `ts_data` is 12 bits.

## Structure
- Shared package `ts_pkg`:
  - FSM state enum `ov_state_t` (2 bits).
  - Widths `TS_SEC_W=6`, `TS_MIN_W=6`, `TS_HR_W=5`.
  - `TS_DATA_W`, conditional on `TS_HOURS_EN`.
- One sub-module: `ts_rr_arbiter` (2-way round-robin with blackout input). Prescaler and FSM stay in the top level.

## Test plan
- PRESCALE=4, `run`=1 from reset release → `tick_en` high on cycles 4, 8, 12. Drop `run` at cycle 9 → no tick at 12; restart → tick 4 cycles later.
- Pulse `ovf_in`=1 → `ovf_irq`=1 next cycle. `ovf_ack` at cycle +5 → `rst_ovf` one pulse at +6. Drop `ovf_in` at +7 → `ovf_irq`=0; FSM idle.
- `ovf_in` held high after `rst_ovf` → FSM re-enters OV_PEND 2 cycles after the clear; `ovf_irq` reasserts.
- `req`=2'b11 continuous, no ticks → `gnt` sequence 01, 10, 01, 10. `ts_data` equals `{min_in, sec_in}` sampled each grant.
- `req[0]` asserted on a tick cycle with `sec_in` 59→0 → grant is delayed 2 cycles; `ts_data`=`{min+1, 0}`, no torn value.
- Assert `reset`=0 while in OV_PEND with `req` pending → all outputs 0 immediately. With TS_HOURS_EN, `hours`=0 after release.
